// File: rtl/fp_div_norm_round.sv
// ---------------------------------------------------------------------------
// fp_div_norm_round
//   Post-divider normalize / round / pack stage of the FP divide path.
//   Takes the fixed-point quotient {q,f} from the mantissa divider plus the
//   sign and tentative biased exponent from unpack. It normalizes one bit per
//   cycle, rounds to nearest-even, and packs an IEEE-754 binary32 result.
//   Overflow saturates to infinity and underflow flushes to zero (no
//   denormals). Divide-by-zero produces infinity.
//
// Ports
//   clk        rising-edge clock
//   arst       asynchronous active-high reset
//   start      request, sampled only in IDLE
//   sign_in    result sign (sign_a ^ sign_b)
//   exp_in     signed biased exponent (ea - eb + bias), EXP_W+2 bits
//   z_in       quotient: integer part [2W-1:W], fraction [W-1:0]
//   dbz_in     divide-by-zero flag from the divider
//   result     packed {sign, exp, frac}, registered
//   overflow   result forced to infinity by exponent overflow
//   underflow  result flushed to zero by exponent underflow
//   done       result valid; high only in DONE
// ---------------------------------------------------------------------------
module fp_div_norm_round #(
    parameter int WIDTH = 24,
    parameter int EXP_W = 8
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   start,
    input  logic                   sign_in,
    input  logic [EXP_W+1:0]       exp_in,
    input  logic [2*WIDTH-1:0]     z_in,
    input  logic                   dbz_in,
    output logic [EXP_W+WIDTH-1:0] result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   done
);

    localparam int ZW = 2 * WIDTH;
    // Three extra exponent bits: sign plus headroom so 2W shifts never wrap.
    localparam int XW = EXP_W + 3;

    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_PACK,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ZW-1:0]          r_z;
    logic signed [XW-1:0]   r_exp;
    logic                   r_sign;
    logic                   r_sticky;
    logic                   r_dbz;
    logic [WIDTH-2:0]       r_frac;
    logic [EXP_W+WIDTH-1:0] r_result;
    logic                   r_overflow;
    logic                   r_underflow;

    logic                   w_z_zero;
    logic                   w_hi_nz;
    logic                   w_round_up;
    logic [WIDTH:0]         w_mant_sum;

    assign w_z_zero = (r_z == '0);
    // Any set bit above the hidden-bit position means a right shift is due.
    assign w_hi_nz  = |r_z[ZW-1:WIDTH+1];

    // Mantissa is z[W:1]; z[0] is the guard bit. Ties go to even, but any
    // bit lost to a right shift (sticky) breaks the tie upward.
    assign w_round_up = r_z[0] & (r_sticky | r_z[1]);
    assign w_mant_sum = {1'b0, r_z[WIDTH:1]} + {{WIDTH{1'b0}}, w_round_up};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default assigned first so no path leaves w_next unassigned,
        // which would otherwise infer a latch.
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_NORM;
            S_NORM: begin
                if (r_dbz || w_z_zero)               w_next = S_PACK;
                else if (!w_hi_nz && r_z[WIDTH])     w_next = S_ROUND;
            end
            S_ROUND: w_next = S_PACK;
            S_PACK:  w_next = S_DONE;
            S_DONE:  if (!start) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // -----------------------------------------------------------------------
    // Datapath: normalize, round, pack
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (arst) begin
            r_z         <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_sticky    <= 1'b0;
            r_dbz       <= 1'b0;
            r_frac      <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_z      <= z_in;
                        r_exp    <= XW'($signed(exp_in));
                        r_sign   <= sign_in;
                        r_dbz    <= dbz_in;
                        r_sticky <= 1'b0;
                    end
                end
                S_NORM: begin
                    if (r_dbz || w_z_zero) begin
                        // Special operand: nothing to normalize.
                    end else if (w_hi_nz) begin
                        r_z      <= r_z >> 1;
                        r_sticky <= r_sticky | r_z[0];
                        r_exp    <= r_exp + EXP_ONE;
                    end else if (!r_z[WIDTH]) begin
                        r_z   <= r_z << 1;
                        r_exp <= r_exp - EXP_ONE;
                    end
                end
                S_ROUND: begin
                    // On carry-out the sum is exactly 2^W, so its low bits
                    // are already the zero fraction of the next binade.
                    r_frac <= w_mant_sum[WIDTH-2:0];
                    if (w_mant_sum[WIDTH]) r_exp <= r_exp + EXP_ONE;
                end
                S_PACK: begin
                    r_overflow  <= 1'b0;
                    r_underflow <= 1'b0;
                    if (r_dbz) begin
                        r_result <= {r_sign, {EXP_W{1'b1}}, {(WIDTH-1){1'b0}}};
                    end else if (w_z_zero) begin
                        r_result <= {r_sign, {(EXP_W+WIDTH-1){1'b0}}};
                    end else if (r_exp >= EXP_MAX) begin
                        r_result   <= {r_sign, {EXP_W{1'b1}}, {(WIDTH-1){1'b0}}};
                        r_overflow <= 1'b1;
                    end else if (r_exp <= EXP_ZERO) begin
                        r_result    <= {r_sign, {(EXP_W+WIDTH-1){1'b0}}};
                        r_underflow <= 1'b1;
                    end else begin
                        r_result <= {r_sign, r_exp[EXP_W-1:0], r_frac};
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_fp_div_norm_round.sv
// ---------------------------------------------------------------------------
// tb_fp_div_norm_round
//   Table of hand-computed binary32 vectors run through a scoreboard queue,
//   plus hand-written sequences for start-held, mid-operation start pulses
//   and asynchronous reset during NORM.
// ---------------------------------------------------------------------------
module tb_fp_div_norm_round;

    localparam int WIDTH = 24;
    localparam int EXP_W = 8;
    localparam int RW    = EXP_W + WIDTH;

    logic             clk = 1'b0;
    logic             arst;
    logic             start;
    logic             sign_in;
    logic [EXP_W+1:0] exp_in;
    logic [2*WIDTH-1:0] z_in;
    logic             dbz_in;
    logic [RW-1:0]    result;
    logic             overflow;
    logic             underflow;
    logic             done;

    fp_div_norm_round #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk       (clk),
        .arst      (arst),
        .start     (start),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .z_in      (z_in),
        .dbz_in    (dbz_in),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             sign;
        logic [EXP_W+1:0] exp;
        logic [2*WIDTH-1:0] z;
        logic             dbz;
        logic [RW-1:0]    res;
        logic             ov;
        logic             uf;
        logic [7:0]       lat;
    } vec_t;

    typedef struct {
        logic [RW-1:0] res;
        logic          ov;
        logic          uf;
        int            lat;
    } exp_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    exp_t sb_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        sign_in = v.sign;
        exp_in  = v.exp;
        z_in    = v.z;
        dbz_in  = v.dbz;
    endtask

    // Runs one vector. The edge that samples start counts as cycle 1, so the
    // no-shift case raises done on cycle 4. With disturb set, a stray start
    // with different operands is pulsed mid-operation and must be ignored.
    task automatic run_vec(input int idx, input bit disturb);
        vec_t v;
        exp_t e;
        exp_t got_e;
        int   lat;
        bit   got;
        string tag;
        v = vecs[idx];
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        drive(v);
        start = 1'b1;
        e.res = v.res; e.ov = v.ov; e.uf = v.uf; e.lat = int'(v.lat);
        sb_q.push_back(e);
        @(posedge clk);
        lat = 1;
        #1 start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (disturb && lat == 5) begin
                start  = 1'b1;
                z_in   = 48'h000001_000000;
                exp_in = 10'd5;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        got_e = sb_q.pop_front();
        if (!got) begin
            check({tag, "_timeout"}, 64'(got), 64'd1);
        end else begin
            check({tag, "_result"},    64'(result),    64'(got_e.res));
            check({tag, "_overflow"},  64'(overflow),  64'(got_e.ov));
            check({tag, "_underflow"}, 64'(underflow), 64'(got_e.uf));
            check({tag, "_latency"},   64'(lat),       64'(got_e.lat));
        end
        // start is low, so DONE returns to IDLE on the next edge.
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_hold_idle"}, 64'(result), 64'(got_e.res));
    endtask

    initial begin
        //            sign exp     z                    dbz result        ov    uf    lat
        vecs[0]  = '{1'b0, 10'd127, 48'h000001_000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 8'd4};  // identity
        vecs[1]  = '{1'b0, 10'd127, 48'h000000_C00000, 1'b0, 32'h3F400000, 1'b0, 1'b0, 8'd5};  // left shift
        vecs[2]  = '{1'b0, 10'd127, 48'h000003_000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 8'd5};  // right shift
        vecs[3]  = '{1'b0, 10'd127, 48'h000001_000001, 1'b0, 32'h3F800000, 1'b0, 1'b0, 8'd4};  // tie, even
        vecs[4]  = '{1'b0, 10'd127, 48'h000001_000003, 1'b0, 32'h3F800002, 1'b0, 1'b0, 8'd4};  // tie, odd
        vecs[5]  = '{1'b0, 10'd127, 48'h000001_FFFFFF, 1'b0, 32'h40000000, 1'b0, 1'b0, 8'd4};  // carry out
        vecs[6]  = '{1'b0, 10'd254, 48'h000003_000000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 8'd5};  // overflow
        vecs[7]  = '{1'b1, 10'd1,   48'h000000_800000, 1'b0, 32'h80000000, 1'b0, 1'b1, 8'd5};  // underflow
        vecs[8]  = '{1'b1, 10'd127, 48'h000001_000000, 1'b1, 32'hFF800000, 1'b0, 1'b0, 8'd3};  // dbz
        vecs[9]  = '{1'b0, 10'd127, 48'h000000_000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 8'd3};  // zero
        vecs[10] = '{1'b0, 10'd127, 48'h000002_000003, 1'b0, 32'h40000001, 1'b0, 1'b0, 8'd5};  // sticky breaks tie
        vecs[11] = '{1'b0, 10'd100, 48'h800000_000000, 1'b0, 32'h3D800000, 1'b0, 1'b0, 8'd27}; // 23 right shifts
        vecs[12] = '{1'b0, 10'd150, 48'h000000_000001, 1'b0, 32'h3F000000, 1'b0, 1'b0, 8'd28}; // 24 left shifts
        vecs[13] = '{1'b0, 10'h3FB, 48'h000001_000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 8'd4};  // exp_in = -5
        vecs[14] = '{1'b0, 10'd255, 48'h000001_000000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 8'd4};  // exp = 255
        vecs[15] = '{1'b0, 10'd254, 48'h000001_000000, 1'b0, 32'h7F000000, 1'b0, 1'b0, 8'd4};  // largest normal
        vecs[16] = '{1'b1, 10'd127, 48'h000001_000000, 1'b0, 32'hBF800000, 1'b0, 1'b0, 8'd4};  // negative
        vecs[17] = '{1'b0, 10'd1,   48'h000001_000000, 1'b0, 32'h00800000, 1'b0, 1'b0, 8'd4};  // smallest normal

        arst    = 1'b1;
        start   = 1'b0;
        sign_in = 1'b0;
        exp_in  = '0;
        z_in    = '0;
        dbz_in  = 1'b0;
        #12;
        check("reset_result",    64'(result),    64'd0);
        check("reset_overflow",  64'(overflow),  64'd0);
        check("reset_underflow", 64'(underflow), 64'd0);
        check("reset_done",      64'(done),      64'd0);
        @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i, 1'b0);

        // Stray start pulse during NORM must not disturb the operation.
        run_vec(11, 1'b1);

        // Start held high: done and result stay put until start drops.
        begin
            int  lat;
            bit  got;
            @(negedge clk);
            drive(vecs[0]);
            start = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(posedge clk);
                #1;
                if (done) begin
                    got = 1'b1;
                    break;
                end
            end
            check("hold_reached_done", 64'(got), 64'd1);
            z_in = 48'h000003_000000;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                #1;
                check($sformatf("hold_done_c%0d", k), 64'(done), 64'd1);
                check($sformatf("hold_result_c%0d", k), 64'(result), 64'h3F800000);
            end
            start = 1'b0;
            @(posedge clk);
            #1;
            check("hold_release_done", 64'(done), 64'd0);
            check("hold_release_result", 64'(result), 64'h3F800000);
        end

        // Asynchronous reset in the middle of NORM.
        @(negedge clk);
        drive(vecs[11]);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 arst = 1'b1;
        #1;
        check("midreset_result",    64'(result),    64'd0);
        check("midreset_overflow",  64'(overflow),  64'd0);
        check("midreset_underflow", 64'(underflow), 64'd0);
        check("midreset_done",      64'(done),      64'd0);
        @(negedge clk);
        arst = 1'b0;
        run_vec(2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
